// File: rtl/avalon_block_master.sv
// Avalon-MM block master: moves LENGTH consecutive words starting at BASE_ADDRESS,
// either reading them out to READ_DATA or writing user-supplied words, with abort.
module avalon_block_master #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned LEN_WIDTH     = 16
) (
    input  logic                     CSI_CLOCK_CLK,
    input  logic                     CSI_CLOCK_RESET,
    input  logic                     START,
    input  logic                     WRITE_MODE,
    input  logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS,
    input  logic [LEN_WIDTH-1:0]     LENGTH,
    input  logic                     ABORT,
    input  logic [DATA_WIDTH-1:0]    WR_DATA,
    input  logic                     WR_DATA_VALID,
    output logic                     WR_DATA_READY,
    output logic [DATA_WIDTH-1:0]    READ_DATA,
    output logic                     READ_VALID,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ABORTED,
    output logic [LEN_WIDTH-1:0]     WORDS_DONE,
    output logic [ADDRESS_WIDTH-1:0] AVM_AVALONMASTER_ADDRESS,
    output logic                     AVM_AVALONMASTER_READ,
    output logic                     AVM_AVALONMASTER_WRITE,
    output logic [DATA_WIDTH-1:0]    AVM_AVALONMASTER_WRITEDATA,
    input  logic [DATA_WIDTH-1:0]    AVM_AVALONMASTER_READDATA,
    input  logic                     AVM_AVALONMASTER_WAITREQUEST
);

    localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = ADDRESS_WIDTH'(BYTES_PER_WORD);

    typedef enum logic [2:0] {IDLE, RD, WR_FILL, WR, FIN} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 abort_req;
    logic                 last_word;
    logic                 abort_hit;

    // An ABORT seen while an access is stalled is remembered until the access completes.
    assign abort_hit = ABORT || abort_req;
    assign last_word = (WORDS_DONE == len_q - LEN_WIDTH'(1));

    // Bus strobes and status decode straight from the state register.
    assign AVM_AVALONMASTER_READ  = (state == RD);
    assign AVM_AVALONMASTER_WRITE = (state == WR);
    assign WR_DATA_READY          = (state == WR_FILL);
    assign BUSY                   = (state != IDLE);

    always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
        if (CSI_CLOCK_RESET) begin
            state                      <= IDLE;
            len_q                      <= '0;
            abort_req                  <= 1'b0;
            AVM_AVALONMASTER_ADDRESS   <= '0;
            AVM_AVALONMASTER_WRITEDATA <= '0;
            READ_DATA                  <= '0;
            READ_VALID                 <= 1'b0;
            DONE                       <= 1'b0;
            ABORTED                    <= 1'b0;
            WORDS_DONE                 <= '0;
        end else begin
            READ_VALID <= 1'b0;
            DONE       <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        AVM_AVALONMASTER_ADDRESS <= BASE_ADDRESS;
                        len_q                    <= LENGTH;
                        WORDS_DONE               <= '0;
                        ABORTED                  <= 1'b0;
                        abort_req                <= 1'b0;
                        if (LENGTH == '0) begin
                            state <= FIN;
                        end else if (WRITE_MODE) begin
                            state <= WR_FILL;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (!AVM_AVALONMASTER_WAITREQUEST) begin
                        READ_DATA                <= AVM_AVALONMASTER_READDATA;
                        READ_VALID               <= 1'b1;
                        AVM_AVALONMASTER_ADDRESS <= AVM_AVALONMASTER_ADDRESS + ADDR_STEP;
                        WORDS_DONE               <= WORDS_DONE + LEN_WIDTH'(1);
                        if (last_word || abort_hit) begin
                            state     <= FIN;
                            ABORTED   <= abort_hit;
                            abort_req <= 1'b0;
                        end
                    end else if (ABORT) begin
                        abort_req <= 1'b1;
                    end
                end
                WR_FILL: begin
                    // A valid word wins over ABORT: it is written first, then the block stops.
                    if (WR_DATA_VALID) begin
                        AVM_AVALONMASTER_WRITEDATA <= WR_DATA;
                        state                      <= WR;
                        if (ABORT) begin
                            abort_req <= 1'b1;
                        end
                    end else if (ABORT) begin
                        state   <= FIN;
                        ABORTED <= 1'b1;
                    end
                end
                WR: begin
                    if (!AVM_AVALONMASTER_WAITREQUEST) begin
                        AVM_AVALONMASTER_ADDRESS <= AVM_AVALONMASTER_ADDRESS + ADDR_STEP;
                        WORDS_DONE               <= WORDS_DONE + LEN_WIDTH'(1);
                        if (last_word || abort_hit) begin
                            state     <= FIN;
                            ABORTED   <= abort_hit;
                            abort_req <= 1'b0;
                        end else begin
                            state <= WR_FILL;
                        end
                    end else if (ABORT) begin
                        abort_req <= 1'b1;
                    end
                end
                FIN: begin
                    DONE  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_block_master.sv
// Directed bench for avalon_block_master: per-cycle read vector tables plus
// hand-written write, abort and reset sequences.
module tb_avalon_block_master;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, write_mode, abort, wr_data_valid, waitreq;
    logic [AW-1:0] base_address;
    logic [LW-1:0] length;
    logic [DW-1:0] wr_data, readdata;
    logic          wr_data_ready, read_valid, busy, done, aborted;
    logic          avm_read, avm_write;
    logic [DW-1:0] read_data, writedata;
    logic [AW-1:0] address;
    logic [LW-1:0] words_done;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    avalon_block_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .CSI_CLOCK_CLK                (clk),
        .CSI_CLOCK_RESET              (rst),
        .START                        (start),
        .WRITE_MODE                   (write_mode),
        .BASE_ADDRESS                 (base_address),
        .LENGTH                       (length),
        .ABORT                        (abort),
        .WR_DATA                      (wr_data),
        .WR_DATA_VALID                (wr_data_valid),
        .WR_DATA_READY                (wr_data_ready),
        .READ_DATA                    (read_data),
        .READ_VALID                   (read_valid),
        .BUSY                         (busy),
        .DONE                         (done),
        .ABORTED                      (aborted),
        .WORDS_DONE                   (words_done),
        .AVM_AVALONMASTER_ADDRESS     (address),
        .AVM_AVALONMASTER_READ        (avm_read),
        .AVM_AVALONMASTER_WRITE       (avm_write),
        .AVM_AVALONMASTER_WRITEDATA   (writedata),
        .AVM_AVALONMASTER_READDATA    (readdata),
        .AVM_AVALONMASTER_WAITREQUEST (waitreq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        logic          start, abort, waitreq;
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        logic [DW-1:0] rdata;
        logic          e_read, e_busy, e_done, e_rvalid, e_aborted;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_rdata;
        logic [LW-1:0] e_words;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic ab, logic wq, logic [AW-1:0] b, logic [LW-1:0] l,
                                logic [DW-1:0] rd, logic e_rd, logic e_bz, logic e_dn, logic e_rv,
                                logic e_ab, logic [AW-1:0] e_ad, logic [DW-1:0] e_rdt,
                                logic [LW-1:0] e_w);
        vec_t v;
        v.start = st; v.abort = ab; v.waitreq = wq; v.base = b; v.len = l; v.rdata = rd;
        v.e_read = e_rd; v.e_busy = e_bz; v.e_done = e_dn; v.e_rvalid = e_rv; v.e_aborted = e_ab;
        v.e_addr = e_ad; v.e_rdata = e_rdt; v.e_words = e_w;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string name, input logic e_write, input logic e_ready,
                          input logic [AW-1:0] e_addr, input logic [DW-1:0] e_wdata,
                          input logic [LW-1:0] e_words);
        chk({name, " write"}, 64'(avm_write), 64'(e_write));
        chk({name, " read"}, 64'(avm_read), 64'd0);
        chk({name, " ready"}, 64'(wr_data_ready), 64'(e_ready));
        chk({name, " addr"}, 64'(address), 64'(e_addr));
        chk({name, " wdata"}, 64'(writedata), 64'(e_wdata));
        chk({name, " words"}, 64'(words_done), 64'(e_words));
    endtask

    task automatic start_write(input logic [AW-1:0] b, input logic [LW-1:0] l);
        start = 1'b1; write_mode = 1'b1; base_address = b; length = l;
        tick();
        start = 1'b0; write_mode = 1'b0;
    endtask

    initial begin
        int dc;
        rst = 1'b1;
        start = 1'b0; write_mode = 1'b0; abort = 1'b0; wr_data_valid = 1'b0; waitreq = 1'b0;
        base_address = '0; length = '0; wr_data = '0; readdata = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst read", 64'(avm_read), 64'd0);
        chk("rst write", 64'(avm_write), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst rvalid", 64'(read_valid), 64'd0);
        chk("rst aborted", 64'(aborted), 64'd0);
        chk("rst ready", 64'(wr_data_ready), 64'd0);
        chk("rst addr", 64'(address), 64'd0);
        chk("rst wdata", 64'(writedata), 64'd0);
        chk("rst rdata", 64'(read_data), 64'd0);
        chk("rst words", 64'(words_done), 64'd0);
        rst = 1'b0;
        tick();

        //            st ab wq base          len  rdata         rd bz dn rv ab addr          rdata         words
        // Three back-to-back reads; a second START while busy is ignored.
        vecs.push_back(mk(1, 0, 0, 32'h100, 16'd3, 32'h0,      1, 1, 0, 0, 0, 32'h100, 32'h0,      16'd0));
        vecs.push_back(mk(1, 0, 0, 32'h500, 16'd7, 32'hA0A0_0000, 1, 1, 0, 1, 0, 32'h104, 32'hA0A0_0000, 16'd1));
        vecs.push_back(mk(0, 0, 0, 32'h0,   16'd0, 32'hA1A1_0001, 1, 1, 0, 1, 0, 32'h108, 32'hA1A1_0001, 16'd2));
        vecs.push_back(mk(0, 0, 0, 32'h0,   16'd0, 32'hA2A2_0002, 0, 1, 0, 1, 0, 32'h10C, 32'hA2A2_0002, 16'd3));
        vecs.push_back(mk(0, 0, 0, 32'h0,   16'd0, 32'h0,      0, 0, 1, 0, 0, 32'h10C, 32'hA2A2_0002, 16'd3));
        vecs.push_back(mk(0, 0, 0, 32'h0,   16'd0, 32'h0,      0, 0, 0, 0, 0, 32'h10C, 32'hA2A2_0002, 16'd3));
        // LENGTH=0: straight to FIN; ABORT ignored in FIN and IDLE.
        vecs.push_back(mk(1, 0, 0, 32'h40,  16'd0, 32'h0,      0, 1, 0, 0, 0, 32'h40,  32'hA2A2_0002, 16'd0));
        vecs.push_back(mk(0, 1, 0, 32'h0,   16'd0, 32'h0,      0, 0, 1, 0, 0, 32'h40,  32'hA2A2_0002, 16'd0));
        vecs.push_back(mk(0, 1, 0, 32'h0,   16'd0, 32'h0,      0, 0, 0, 0, 0, 32'h40,  32'hA2A2_0002, 16'd0));
        // Abort pulse during a stalled second read of five.
        vecs.push_back(mk(1, 0, 0, 32'h200, 16'd5, 32'h0,      1, 1, 0, 0, 0, 32'h200, 32'hA2A2_0002, 16'd0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   16'd0, 32'hB0B0_0000, 1, 1, 0, 1, 0, 32'h204, 32'hB0B0_0000, 16'd1));
        vecs.push_back(mk(0, 1, 1, 32'h0,   16'd0, 32'hDEAD_BEEF, 1, 1, 0, 0, 0, 32'h204, 32'hB0B0_0000, 16'd1));
        vecs.push_back(mk(0, 0, 1, 32'h0,   16'd0, 32'hDEAD_BEEF, 1, 1, 0, 0, 0, 32'h204, 32'hB0B0_0000, 16'd1));
        vecs.push_back(mk(0, 0, 0, 32'h0,   16'd0, 32'hB1B1_0001, 0, 1, 0, 1, 1, 32'h208, 32'hB1B1_0001, 16'd2));
        vecs.push_back(mk(0, 0, 0, 32'h0,   16'd0, 32'h0,      0, 0, 1, 0, 1, 32'h208, 32'hB1B1_0001, 16'd2));
        // Address wraps past the top of the address space; new START clears ABORTED.
        vecs.push_back(mk(1, 0, 0, 32'hFFFF_FFFC, 16'd2, 32'h0, 1, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'hB1B1_0001, 16'd0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   16'd0, 32'hC0C0_0000, 1, 1, 0, 1, 0, 32'h0,   32'hC0C0_0000, 16'd1));
        vecs.push_back(mk(0, 0, 0, 32'h0,   16'd0, 32'hC1C1_0001, 0, 1, 0, 1, 0, 32'h4,   32'hC1C1_0001, 16'd2));
        vecs.push_back(mk(0, 0, 0, 32'h0,   16'd0, 32'h0,      0, 0, 1, 0, 0, 32'h4,   32'hC1C1_0001, 16'd2));

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start; write_mode = 1'b0; abort = vecs[i].abort;
            waitreq = vecs[i].waitreq; base_address = vecs[i].base; length = vecs[i].len;
            readdata = vecs[i].rdata;
            tick();
            chk($sformatf("v%0d read", i), 64'(avm_read), 64'(vecs[i].e_read));
            chk($sformatf("v%0d write", i), 64'(avm_write), 64'd0);
            chk($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
            chk($sformatf("v%0d done", i), 64'(done), 64'(vecs[i].e_done));
            chk($sformatf("v%0d rvalid", i), 64'(read_valid), 64'(vecs[i].e_rvalid));
            chk($sformatf("v%0d aborted", i), 64'(aborted), 64'(vecs[i].e_aborted));
            chk($sformatf("v%0d addr", i), 64'(address), 64'(vecs[i].e_addr));
            chk($sformatf("v%0d rdata", i), 64'(read_data), 64'(vecs[i].e_rdata));
            chk($sformatf("v%0d words", i), 64'(words_done), 64'(vecs[i].e_words));
        end
        start = 1'b0; abort = 1'b0; waitreq = 1'b0;
        tick();

        // Two-word write, first word stalled by WAITREQUEST for four edges.
        dc = done_cnt;
        start_write(32'h300, 16'd2);
        chk_wr("w44 fill", 1'b0, 1'b1, 32'h300, 32'h0, 16'd0);
        tick();
        chk_wr("w44 fill wait", 1'b0, 1'b1, 32'h300, 32'h0, 16'd0);
        wr_data_valid = 1'b1; wr_data = 32'h1111_2222; waitreq = 1'b1;
        tick();
        wr_data_valid = 1'b0; wr_data = 32'h9999_9999;
        chk_wr("w44 wr0", 1'b1, 1'b0, 32'h300, 32'h1111_2222, 16'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_wr($sformatf("w44 stall%0d", k), 1'b1, 1'b0, 32'h300, 32'h1111_2222, 16'd0);
        end
        waitreq = 1'b0;
        tick();
        chk_wr("w44 refill", 1'b0, 1'b1, 32'h304, 32'h1111_2222, 16'd1);
        wr_data_valid = 1'b1; wr_data = 32'h3333_4444;
        tick();
        wr_data_valid = 1'b0;
        chk_wr("w44 wr1", 1'b1, 1'b0, 32'h304, 32'h3333_4444, 16'd1);
        tick();
        chk_wr("w44 fin", 1'b0, 1'b0, 32'h308, 32'h3333_4444, 16'd2);
        chk("w44 fin busy", 64'(busy), 64'd1);
        tick();
        chk("w44 done", 64'(done), 64'd1);
        chk("w44 busy end", 64'(busy), 64'd0);
        chk("w44 aborted", 64'(aborted), 64'd0);
        repeat (3) tick();
        chk("w44 done count", 64'(done_cnt - dc), 64'd1);

        // Valid word and ABORT together in WR_FILL: word written, then abort.
        start_write(32'h400, 16'd3);
        wr_data_valid = 1'b1; abort = 1'b1; wr_data = 32'h5555_6666;
        tick();
        wr_data_valid = 1'b0; abort = 1'b0;
        chk_wr("vab wr", 1'b1, 1'b0, 32'h400, 32'h5555_6666, 16'd0);
        tick();
        chk_wr("vab fin", 1'b0, 1'b0, 32'h404, 32'h5555_6666, 16'd1);
        chk("vab aborted", 64'(aborted), 64'd1);
        tick();
        chk("vab done", 64'(done), 64'd1);
        chk("vab busy", 64'(busy), 64'd0);

        // ABORT in WR_FILL with no word: nothing written.
        start_write(32'h500, 16'd2);
        chk("fab cleared", 64'(aborted), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_wr("fab fin", 1'b0, 1'b0, 32'h500, 32'h5555_6666, 16'd0);
        chk("fab aborted", 64'(aborted), 64'd1);
        tick();
        chk("fab done", 64'(done), 64'd1);

        // Reset mid-write while stalled: strobes drop without a clock edge, no DONE.
        tick();
        start_write(32'h600, 16'd1);
        wr_data_valid = 1'b1; wr_data = 32'h7777_8888; waitreq = 1'b1;
        tick();
        wr_data_valid = 1'b0;
        chk("rstm write before", 64'(avm_write), 64'd1);
        dc = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("rstm write", 64'(avm_write), 64'd0);
        chk("rstm busy", 64'(busy), 64'd0);
        chk("rstm addr", 64'(address), 64'd0);
        chk("rstm wdata", 64'(writedata), 64'd0);
        repeat (2) tick();
        rst = 1'b0; waitreq = 1'b0;
        repeat (3) tick();
        chk("rstm no done", 64'(done_cnt - dc), 64'd0);
        chk("rstm idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/avalon_block_master.md
AVALON_BLOCK_MASTER -- requirements
Module: avalon_block_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning Avalon data width in bits (multiple of 8, at least 8).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, meaning Avalon byte-address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, meaning width of the transfer word-count field.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, using the codebase clock/reset port naming.
REQ-005 SHALL have port CSI_CLOCK_CLK  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port CSI_CLOCK_RESET  in  1  asynchronous active-high reset.
REQ-007 SHALL have port START  in  1  command request; sampled only in IDLE.
REQ-008 SHALL have port WRITE_MODE  in  1  1 = write block, 0 = read block; sampled with START.
REQ-009 SHALL have port BASE_ADDRESS  in  ADDRESS_WIDTH  first byte address; sampled with START.
REQ-010 SHALL have port LENGTH  in  LEN_WIDTH  number of words; sampled with START.
REQ-011 SHALL have port ABORT  in  1  stop the block after the current access.
REQ-012 SHALL have port WR_DATA  in  DATA_WIDTH  user write word.
REQ-013 SHALL have port WR_DATA_VALID  in  1  WR_DATA is valid.
REQ-014 SHALL have port WR_DATA_READY  out  1  block accepts WR_DATA this cycle.
REQ-015 SHALL have port READ_DATA  out  DATA_WIDTH  last word read.
REQ-016 SHALL have port READ_VALID  out  1  one-cycle pulse; READ_DATA is new.
REQ-017 SHALL have port BUSY  out  1  high in every state except IDLE.
REQ-018 SHALL have port DONE  out  1  one-cycle pulse at block end.
REQ-019 SHALL have port ABORTED  out  1  last block ended by ABORT; held until next accepted START.
REQ-020 SHALL have port WORDS_DONE  out  LEN_WIDTH  completed accesses in current or last block.
REQ-021 SHALL have Avalon master ports AVM_AVALONMASTER_ADDRESS (out, ADDRESS_WIDTH), _READ (out, 1), _WRITE (out, 1), _WRITEDATA (out, DATA_WIDTH), _READDATA (in, DATA_WIDTH) and _WAITREQUEST (in, 1).

Function
REQ-022 SHALL implement five states: IDLE, RD, WR_FILL, WR and FIN.
REQ-023 SHALL, in IDLE with START=1, latch the address, LENGTH and mode, clear WORDS_DONE and ABORTED, and go to FIN if LENGTH=0, otherwise to RD (read mode) or WR_FILL (write mode).
REQ-024 SHALL drive AVM READ=1 only in RD and AVM WRITE=1 only in WR; both are decoded from registered state and never high together.
REQ-025 SHALL hold ADDRESS, WRITEDATA and READ/WRITE stable while WAITREQUEST=1.
REQ-026 SHALL, in RD with WAITREQUEST=0, register READDATA into READ_DATA and pulse READ_VALID on the next cycle.
REQ-027 SHALL, in RD with WAITREQUEST=0, also add DATA_WIDTH/8 to the address, increment WORDS_DONE, and go to FIN on the last word; otherwise it SHALL stay in RD, giving back-to-back reads.
REQ-028 SHALL, in WR_FILL, assert WR_DATA_READY=1.
REQ-029 SHALL, in WR_FILL with WR_DATA_VALID=1, register WR_DATA into WRITEDATA and go to WR; with WR_DATA_VALID=0 it SHALL wait indefinitely.
REQ-030 SHALL, in WR with WAITREQUEST=0, advance the address, increment WORDS_DONE, and go to FIN on the last word, otherwise to WR_FILL.
REQ-031 SHALL, in FIN, assert DONE=1 for exactly one cycle and then go to IDLE.
REQ-032 SHALL, on ABORT=1 in RD or WR, complete the access in flight (wait for WAITREQUEST=0), then go to FIN and set ABORTED.
REQ-033 SHALL, on ABORT=1 in WR_FILL, go to FIN next cycle and set ABORTED, with no word accepted.
REQ-034 SHALL ignore ABORT in IDLE and in FIN.
REQ-035 SHALL ignore START while BUSY=1.
REQ-036 SHALL wrap address arithmetic modulo 2^ADDRESS_WIDTH.
REQ-037 SHALL treat LENGTH = 2^LEN_WIDTH-1 as a legal block length.
REQ-038 SHALL give WR_DATA_VALID priority over ABORT when both are high in WR_FILL: the word is accepted and written, then the block aborts.

Reset
REQ-039 SHALL, while CSI_CLOCK_RESET=1, immediately force state IDLE.
REQ-040 SHALL, while CSI_CLOCK_RESET=1, drive READ, WRITE, READ_VALID, DONE, BUSY, ABORTED and WR_DATA_READY to 0.
REQ-041 SHALL, while CSI_CLOCK_RESET=1, clear ADDRESS, WRITEDATA, READ_DATA and WORDS_DONE to 0.
REQ-042 SHALL, on reset mid-block, abandon the block without emitting DONE.

Verification
REQ-043 SHALL cover: read START, BASE=0x100, LENGTH=3, WAITREQUEST=0 -> READ on 3 consecutive cycles at 0x100/0x104/0x108, 3 READ_VALID pulses, DONE one cycle later, WORDS_DONE=3.
REQ-044 SHALL cover: write LENGTH=2, WAITREQUEST high 4 cycles on first word -> ADDRESS/WRITEDATA stable for those 4 cycles, second write at BASE+4, DONE once.
REQ-045 SHALL cover: LENGTH=0 -> no READ/WRITE, DONE 2 cycles after START, WORDS_DONE=0.
REQ-046 SHALL cover: ABORT during read word 2 of 5 with WAITREQUEST=1 -> word 2 completes, DONE, ABORTED=1, WORDS_DONE=2.
REQ-047 SHALL cover: BASE=0xFFFFFFFC, LENGTH=2 -> second access at 0x00000000.
REQ-048 SHALL cover: reset asserted in WR with WAITREQUEST=1 -> WRITE drops without a clock edge, BUSY=0, no DONE.
